// File: rtl/cw_matrix_key_scan.sv
// Scanned, debounced 4x4 keypad reader with a valid/ack holding register.
// Define CW_KEY_REPEAT_EN to enable auto-repeat while a key stays held.
`default_nettype none

module cw_matrix_key_scan #(
  parameter int SCAN_DIV     = 10,
  parameter int DEB_SCANS    = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       CLK,
  input  logic       RSTn,
  output logic [3:0] Row_Out,
  input  logic [3:0] Col_In,
  output logic [3:0] oKey_Code,
  output logic       oKey_Valid,
  input  logic       iKey_Ack,
  output logic       oKey_Held,
  output logic       oOverflow,
  input  logic       iClr_Ovf
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DEB,
    S_HELD,
    S_REL_DEB
  } state_t;

  if (SCAN_DIV < 4 || DEB_SCANS < 2 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("cw_matrix_key_scan: illegal parameter value");
  end

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_row;
  logic [15:0]   r_img;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;

  logic          w_tc;
  logic          w_eos;
  logic [15:0]   w_img;
  logic [4:0]    w_nkeys;
  logic [3:0]    w_code;
  logic          w_none;
  logic          w_single;
  state_t        w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [3:0]    w_cand_n;
  logic          w_press_ev;
  logic          w_event;

  assign w_tc    = (r_slot == SW'(SCAN_DIV - 1));
  assign w_eos   = w_tc && (r_row == 2'd3);
  assign Row_Out = ~(4'b0001 << r_row);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_slot  <= '0;
      r_row   <= 2'd0;
      r_img   <= '0;
    end else begin
      r_sync1 <= Col_In;
      r_sync2 <= r_sync1;
      r_slot  <= w_tc ? '0 : r_slot + SW'(1);
      if (w_tc)
        r_row <= r_row + 2'd1;
      r_img   <= w_img;
    end
  end

  // Image bit {row,col} is 1 when pressed; the row-3 sample is merged
  // combinationally so classification at EOS sees the whole scan.
  always_comb begin
    w_img = r_img;
    if (w_tc)
      w_img[{r_row, 2'b00} +: 4] = ~r_sync2;
  end

  always_comb begin
    w_nkeys = '0;
    w_code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_img[i]) begin
        w_nkeys = w_nkeys + 5'd1;
        w_code  = 4'(i);
      end
    end
  end

  assign w_none   = (w_nkeys == 5'd0);
  assign w_single = (w_nkeys == 5'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cand  <= w_cand_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_cand_n   = r_cand;
    w_press_ev = 1'b0;
    if (w_eos) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_state_n = S_PRESS_DEB;
            w_cand_n  = w_code;
            w_cnt_n   = CW'(1);
          end
        end
        S_PRESS_DEB: begin
          if (w_single && (w_code == r_cand)) begin
            w_cnt_n = r_cnt + CW'(1);
            if (r_cnt + CW'(1) == CW'(DEB_SCANS)) begin
              w_press_ev = 1'b1;
              w_state_n  = S_HELD;
            end
          end else begin
            w_state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_none) begin
            w_state_n = S_REL_DEB;
            w_cnt_n   = CW'(1);
          end
        end
        S_REL_DEB: begin
          if (w_none) begin
            w_cnt_n = r_cnt + CW'(1);
            if (r_cnt + CW'(1) == CW'(DEB_SCANS))
              w_state_n = S_IDLE;
          end else begin
            w_state_n = S_HELD;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

`ifdef CW_KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep;
  logic          r_rep_run;
  logic [RW-1:0] w_rep_tgt;
  logic          w_rep_tick;
  logic          w_rep_ev;

  // Only scans that stay in HELD advance the count; RELEASE_DEB freezes it.
  assign w_rep_tgt  = r_rep_run ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
  assign w_rep_tick = w_eos && (r_state == S_HELD) && !w_none;
  assign w_rep_ev   = w_rep_tick && (r_rep + RW'(1) == w_rep_tgt);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rep     <= '0;
      r_rep_run <= 1'b0;
    end else if (w_press_ev) begin
      r_rep     <= '0;
      r_rep_run <= 1'b0;
    end else if (w_rep_ev) begin
      r_rep     <= '0;
      r_rep_run <= 1'b1;
    end else if (w_rep_tick) begin
      r_rep     <= r_rep + RW'(1);
    end
  end

  assign w_event = w_press_ev | w_rep_ev;
`else
  assign w_event = w_press_ev;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      oKey_Code  <= '0;
      oKey_Valid <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      if (w_event && (!oKey_Valid || iKey_Ack)) begin
        oKey_Code  <= r_cand;
        oKey_Valid <= 1'b1;
      end else if (iKey_Ack) begin
        oKey_Valid <= 1'b0;
      end
      if (w_event && oKey_Valid && !iKey_Ack)
        oOverflow <= 1'b1;
      else if (iClr_Ovf)
        oOverflow <= 1'b0;
    end
  end

  assign oKey_Held = (r_state == S_HELD) || (r_state == S_REL_DEB);

endmodule

`default_nettype wire

// File: tb/tb_cw_matrix_key_scan.sv
// Randomized self-checking bench for cw_matrix_key_scan with a
// scan-level keypad/debounce reference model.
module tb_cw_matrix_key_scan;

  localparam int SCAN_DIV = 10;
  localparam int DEB      = 4;
  localparam int RDLY     = 50;
  localparam int RRATE    = 10;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  Row_Out;
  logic [3:0]  Col_In;
  logic [3:0]  oKey_Code;
  logic        oKey_Valid;
  logic        iKey_Ack = 1'b0;
  logic        oKey_Held;
  logic        oOverflow;
  logic        iClr_Ovf = 1'b0;

  logic [15:0] keys = '0;
  bit          auto_ack, eos_ack, eos_clr;
  int          ack_wait;
  logic [3:0]  got[$];
  logic [3:0]  exp_q[$];
  int          n_cmp, n_bad;

  bit          m_held;
  int          m_streak, m_rel, m_rep, m_rep_tgt;
  logic [3:0]  m_code;

  cw_matrix_key_scan #(
    .SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB),
    .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Row_Out(Row_Out), .Col_In(Col_In),
    .oKey_Code(oKey_Code), .oKey_Valid(oKey_Valid),
    .iKey_Ack(iKey_Ack), .oKey_Held(oKey_Held),
    .oOverflow(oOverflow), .iClr_Ovf(iClr_Ovf)
  );

  always #5 CLK = ~CLK;

  // Keypad: a pressed key shorts its row line to its column line.
  function automatic logic [3:0] col_of(input logic [3:0] rows,
                                        input logic [15:0] k);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows[r])
        for (int j = 0; j < 4; j++)
          if (k[r*4+j]) c[j] = 1'b0;
    return c;
  endfunction

  assign Col_In = col_of(Row_Out, keys);

  function automatic logic [15:0] key(input int c);
    return 16'd1 << c;
  endfunction

  task automatic model_reset();
    m_held = 0; m_streak = 0; m_rel = 0;
    m_rep = 0; m_rep_tgt = RDLY; m_code = '0;
  endtask

  task automatic model_scan(input logic [15:0] p);
    int n;
    logic [3:0] c;
    n = $countones(p);
    c = '0;
    for (int i = 0; i < 16; i++) if (p[i]) c = 4'(i);
    if (!m_held) begin
      if (n == 1 && m_streak > 0 && c == m_code) m_streak++;
      else if (n == 1 && m_streak == 0) begin m_streak = 1; m_code = c; end
      else m_streak = 0;
      if (m_streak == DEB) begin
        exp_q.push_back(m_code);
        m_held = 1; m_rel = 0; m_rep = 0; m_rep_tgt = RDLY; m_streak = 0;
      end
    end else begin
`ifdef CW_KEY_REPEAT_EN
      if (m_rel == 0 && n != 0) begin
        m_rep++;
        if (m_rep == m_rep_tgt) begin
          exp_q.push_back(m_code); m_rep = 0; m_rep_tgt = RRATE;
        end
      end
`endif
      if (n == 0) begin
        m_rel++;
        if (m_rel == DEB) m_held = 0;
      end else m_rel = 0;
    end
  endtask

  // One full scan with pattern p, starting and ending on a falling edge.
  task automatic run_scan(input logic [15:0] p);
    keys = p;
    for (int i = 0; i < SCAN; i++) begin
      @(posedge CLK); @(negedge CLK);
      iClr_Ovf = 1'b0;
      if (iKey_Ack) iKey_Ack = 1'b0;
      else if (auto_ack && oKey_Valid) begin
        if (ack_wait == 2) begin
          got.push_back(oKey_Code); iKey_Ack = 1'b1; ack_wait = 0;
        end else ack_wait++;
      end
      if (i == SCAN - 2) begin
        if (eos_ack) iKey_Ack = 1'b1;
        if (eos_clr) iClr_Ovf = 1'b1;
      end
    end
    model_scan(p);
    n_cmp++;
    if (oKey_Held !== m_held) begin
      n_bad++;
      $display("FAIL held: got %b want %b (keys %h)", oKey_Held, m_held, p);
    end
  endtask

  task automatic do_reset();
    iKey_Ack = 0; iClr_Ovf = 0; keys = '0; ack_wait = 0;
    auto_ack = 0; eos_ack = 0; eos_clr = 0;
    RSTn = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic cmp_queues(input string tag);
    n_cmp++;
    if (got.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d want %0d", tag, got.size(), exp_q.size());
    end else begin
      foreach (got[i]) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL %s code[%0d]: got %h want %h", tag, i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    auto_ack = 0;
    repeat (DEB) run_scan(key(6));
    n_cmp++;
    if (oKey_Valid !== 1'b1 || oKey_Code !== 4'h6) begin
      n_bad++;
      $display("FAIL pre_reset: got v=%b c=%h want v=1 c=6", oKey_Valid, oKey_Code);
    end
    repeat (15) @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    n_cmp++;
    if (Row_Out !== 4'b1110 || oKey_Code !== 4'h0 || oKey_Valid !== 1'b0 ||
        oKey_Held !== 1'b0 || oOverflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got row=%b c=%h v=%b h=%b o=%b want 1110/0/0/0/0",
               Row_Out, oKey_Code, oKey_Valid, oKey_Held, oOverflow);
    end
    repeat (2) @(negedge CLK);
    keys = '0; model_reset(); exp_q.delete(); got.delete();
    RSTn = 1'b1;
    for (int i = 0; i < SCAN; i++) begin
      e = ~(4'b0001 << (i / SCAN_DIV));
      n_cmp++;
      if (Row_Out !== e) begin
        n_bad++;
        $display("FAIL row_seq[%0d]: got %b want %b", i, Row_Out, e);
      end
      @(posedge CLK); @(negedge CLK);
    end
    model_scan('0);
    n_cmp++;
    if (oKey_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: got v=%b want 0", oKey_Valid);
    end
  endtask

  task automatic test_clean_press();
    auto_ack = 1; ack_wait = 0; got.delete(); exp_q.delete();
    for (int s = 1; s <= 8; s++) begin
      run_scan(key(9));
      if (s == DEB - 1) begin
        n_cmp++;
        if (oKey_Valid !== 1'b0) begin
          n_bad++; $display("FAIL early_valid: got %b want 0", oKey_Valid);
        end
      end
      if (s == DEB) begin
        n_cmp++;
        if (oKey_Valid !== 1'b1 || oKey_Code !== 4'h9 || oKey_Held !== 1'b1) begin
          n_bad++;
          $display("FAIL press_latency: got v=%b c=%h h=%b want 1/9/1",
                   oKey_Valid, oKey_Code, oKey_Held);
        end
      end
    end
    n_cmp++;
    if (oKey_Valid !== 1'b0) begin
      n_bad++; $display("FAIL ack_clear: got %b want 0", oKey_Valid);
    end
    repeat (DEB) run_scan('0);
    cmp_queues("clean");
  endtask

  task automatic test_bounce();
    auto_ack = 1; ack_wait = 0; got.delete(); exp_q.delete();
    repeat (3) begin
      repeat (DEB - 1) run_scan(key(5));
      run_scan('0);
    end
    n_cmp++;
    if (got.size() != 0 || oKey_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce: got %0d events v=%b want 0/0", got.size(), oKey_Valid);
    end
    cmp_queues("bounce");
  endtask

  task automatic test_multi();
    auto_ack = 1; ack_wait = 0; got.delete(); exp_q.delete();
    repeat (8) run_scan(key(0) | key(5));
    n_cmp++;
    if (got.size() != 0) begin
      n_bad++; $display("FAIL multi_pair: got %0d events want 0", got.size());
    end
    repeat (DEB + 1) run_scan('0);
    repeat (6) run_scan(key(3));
    repeat (6) run_scan(key(3) | key(12));
    repeat (DEB + 1) run_scan('0);
    n_cmp++;
    if (got.size() != 1 || got[0] !== 4'h3) begin
      n_bad++;
      $display("FAIL multi_add: got %0d events first %h want 1 event of 3",
               got.size(), (got.size() > 0) ? got[0] : 4'hx);
    end
    cmp_queues("multi");
  endtask

  task automatic test_overflow();
    auto_ack = 0; got.delete(); exp_q.delete();
    repeat (DEB + 1) run_scan(key(1));
    repeat (DEB + 1) run_scan('0);
    repeat (DEB + 1) run_scan(key(2));
    repeat (DEB + 1) run_scan('0);
    n_cmp++;
    if (oKey_Code !== 4'h1 || oKey_Valid !== 1'b1 || oOverflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow: got c=%h v=%b o=%b want 1/1/1",
               oKey_Code, oKey_Valid, oOverflow);
    end
    iClr_Ovf = 1'b1;
    run_scan('0);
    n_cmp++;
    if (oOverflow !== 1'b0 || oKey_Code !== 4'h1) begin
      n_bad++;
      $display("FAIL clr_ovf: got o=%b c=%h want 0/1", oOverflow, oKey_Code);
    end
    eos_clr = 1;
    repeat (DEB) run_scan(key(3));
    eos_clr = 0;
    n_cmp++;
    if (oOverflow !== 1'b1 || oKey_Code !== 4'h1) begin
      n_bad++;
      $display("FAIL set_wins: got o=%b c=%h want 1/1", oOverflow, oKey_Code);
    end
    repeat (DEB + 1) run_scan('0);
    repeat (DEB - 1) run_scan(key(4));
    eos_ack = 1;
    run_scan(key(4));
    eos_ack = 0;
    n_cmp++;
    if (oKey_Code !== 4'h4 || oKey_Valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_load: got c=%h v=%b want 4/1", oKey_Code, oKey_Valid);
    end
    auto_ack = 1; ack_wait = 0;
    repeat (DEB + 1) run_scan('0);
    n_cmp++;
    if (oKey_Valid !== 1'b0) begin
      n_bad++; $display("FAIL drain: got v=%b want 0", oKey_Valid);
    end
  endtask

  task automatic test_repeat();
    int want;
`ifdef CW_KEY_REPEAT_EN
    want = 4;
`else
    want = 1;
`endif
    auto_ack = 1; ack_wait = 0; got.delete(); exp_q.delete();
    repeat (DEB + RDLY + 2 * RRATE + 3) run_scan(key(15));
    repeat (DEB + 1) run_scan('0);
    n_cmp++;
    if (got.size() != want) begin
      n_bad++;
      $display("FAIL repeat_count: got %0d want %0d", got.size(), want);
    end
    foreach (got[i]) begin
      n_cmp++;
      if (got[i] !== 4'hF) begin
        n_bad++; $display("FAIL repeat_code[%0d]: got %h want f", i, got[i]);
      end
    end
    cmp_queues("repeat");
  endtask

  task automatic test_random();
    int t, len, a, b;
    auto_ack = 1; ack_wait = 0; got.delete(); exp_q.delete();
    for (int seg = 0; seg < 40; seg++) begin
      t = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (t)
        0: begin
          len = $urandom_range(1, 7);
          repeat (len) run_scan(key(a));
        end
        1: begin
          len = $urandom_range(1, 6);
          repeat (len) run_scan('0);
        end
        default: begin
          len = $urandom_range(1, 3);
          repeat (len) run_scan(key(a) | key(b));
        end
      endcase
    end
    repeat (DEB + 1) run_scan('0);
    cmp_queues("random");
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    do_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_overflow();
    test_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cw_matrix_key_scan.md
# cw_matrix_key_scan

Scanned, debounced 4x4 matrix keypad reader: the input-side counterpart of the multiplexed seven-segment display driver. It drives one keypad row at a time, samples the column lines, debounces whole scans and delivers one key code per press through a valid/ack holding register. The clock top level uses it for time-set and alarm-set entry beside the existing switch and key inputs.

## Interface
- SCAN_DIV, 10: CLK cycles per row slot; legal range ≥4.
- DEB_SCANS, 4: consecutive identical full scans required to accept a press or a release; legal range ≥2.
- REPEAT_DELAY, 50: full scans in HELD before the first auto-repeat. Used only with the macro.
- REPEAT_RATE, 10: full scans between later auto-repeats. Used only with the macro.
- CLK  in  1  system clock; all state on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Row_Out  out  4  row drive, one-cold, active low; Row_Out[0] = row 0.
- Col_In  in  4  column sense, active low (pulled up); asynchronous, 2-flop synchronized internally.
- oKey_Code  out  4  {row[1:0], col[1:0]} of the accepted key.
- oKey_Valid  out  1  holding register full; stays high until acked.
- iKey_Ack  in  1  consumer fetched the code; ignored while oKey_Valid=0.
- oKey_Held  out  1  debounced key is down (HELD or RELEASE_DEB).
- oOverflow  out  1  sticky; an event was dropped while the register was full.
- iClr_Ovf  in  1  clears oOverflow.

## Operation
- Slot counter runs 0..SCAN_DIV-1. The terminal count (TC) is the last cycle of a slot.
- At TC the block stores the synchronized Col_In into the 16-bit scan image at the current row, then advances Row_Out cyclically 1110→1101→1011→0111→1110.
- End-of-scan (EOS) is the TC of row 3. The image is classified as NONE (0 keys), SINGLE(code) (exactly 1 key) or MULTI (more than 1 key).
- Debounce FSM is evaluated at EOS only. It has one counter, cnt.
- IDLE:
  - SINGLE(c) → PRESS_DEB, cand=c, cnt=1.
  - Otherwise stay in IDLE.
- PRESS_DEB:
  - SINGLE(cand) → cnt+1. When cnt reaches DEB_SCANS, emit event(cand) and go to HELD.
  - Any other result → IDLE.
- HELD:
  - NONE → RELEASE_DEB, cnt=1.
  - SINGLE of any code or MULTI → stay. A new key is accepted only after a full release.
- RELEASE_DEB:
  - NONE → cnt+1. When cnt reaches DEB_SCANS, go to IDLE.
  - Anything else → HELD.
- Event handling:
  - If oKey_Valid=0, or iKey_Ack=1 in the same cycle: load oKey_Code and set oKey_Valid=1.
  - Otherwise drop the event, keep the pending code, and set oOverflow.
- Ack without a new event clears oKey_Valid.
- If overflow set and iClr_Ovf coincide, set wins.
- Widths: counters are $clog2-sized, with no wrap before the compare.

## Timing
- Reset values:
  - Row_Out=4'b1110, slot counter 0, row 0.
  - oKey_Code=0, oKey_Valid=0, oKey_Held=0, oOverflow=0.
  - FSM in IDLE, scan image all released.
- Deassertion of RSTn mid-operation is not special. Assertion at any time aborts the scan and discards any pending event.
- Column sampling happens SCAN_DIV-1 cycles after the row change. This covers 2 synchronizer cycles plus settling.
- oKey_Valid rises 1 cycle after the EOS cycle that completes press debounce. oKey_Held rises in that same cycle.
- Minimum press-to-valid latency is DEB_SCANS full scans plus 1 cycle after the first scan that fully sees the key.
- oKey_Valid falls 1 cycle after the cycle where iKey_Ack is sampled high.

## Configuration
- CW_KEY_REPEAT_EN defined:
  - In HELD, a scan counter starts at 0 on entry from PRESS_DEB.
  - It emits event(cand) after REPEAT_DELAY scans, then every REPEAT_RATE scans.
  - The counter freezes in RELEASE_DEB and resumes on return to HELD.
  - Repeat events follow the same overflow rules.
- CW_KEY_REPEAT_EN undefined:
  - Exactly one event per debounced press.
  - Repeat logic is absent and REPEAT_* are ignored.

## Test plan
- Reset: hold RSTn low mid-scan. Expect Row_Out=1110 and all outputs 0. After release, Row_Out steps 1110/1101/1011/0111, SCAN_DIV cycles each.
- Clean press: row 2, col 1 pressed for 8 scans, ack 3 cycles after valid. Expect one event with oKey_Code=4'h9 and oKey_Held=1; after ack oKey_Valid=0. Then release: oKey_Held=0 after DEB_SCANS NONE scans, with no further event.
- Bounce: key 4'h5 present for DEB_SCANS-1 scans, then 1 scan absent, repeated. Expect no event and oKey_Held=0.
- Multi-key:
  - Keys 4'h0 and 4'h5 pressed together → no event.
  - Key 4'h3 held, then 4'hC added → no second event.
- Overflow: press/release 4'h1, then 4'h2, with no ack. Expect oKey_Code=1, oOverflow=1. iClr_Ovf → oOverflow=0. A press coincident with ack loads the new code and oKey_Valid stays 1.
- Repeat: hold 4'hF for REPEAT_DELAY+2·REPEAT_RATE scans past acceptance, acking each event. With the macro, expect 4 events; without it, expect 1.
